dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the memory-request interface driven by the processor's MEM stage (MREQ = MEMWRITE | MEMREAD).
- Accepts one request at a time (read/write, size, address, write data), inserts a programmable number of wait states, then returns load data with a one-cycle ACK pulse.
- Holds a word-organised RAM with little-endian byte-lane steering; flags misaligned and out-of-range accesses.

Parameters:
- ADDR_W, 32, width of the byte address.
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; legal word index 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between accept and ACK; 0 is legal.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  synchronous, active-low reset.
- DMEM_inMREQ  in  1  request valid; held high with stable fields until ACK.
- DMEM_inWRITE  in  1  1 = store, 0 = load.
- DMEM_inSIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- DMEM_inADDRESS  in  ADDR_W  byte address.
- DMEM_inWRITEDATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- DMEM_outLOADDATA  out  32  load result, valid only while ACK=1.
- DMEM_outACK  out  1  one-cycle completion pulse.
- DMEM_outBUSY  out  1  high while a request is held (WAIT or RESP).
- DMEM_outERR  out  1  qualifies ACK: request rejected, no RAM change.

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous and active-low on RESETN and has priority over all other activity.
- Reset state: all outputs are 0 and the FSM is in IDLE. RAM contents are not cleared.
- IDLE:
  - If MREQ=1, capture WRITE, SIZE, ADDRESS and WRITEDATA, and set BUSY=1.
  - Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; at 0 go to RESP. Request inputs are ignored (the captured copy is used).
- RESP:
  - ACK=1 for exactly one cycle; ERR and LOADDATA are valid in this cycle. Otherwise LOADDATA=0 and ERR=0.
  - Next state is IDLE.
- Latency: ACK is asserted WAIT_CYCLES+1 cycles after the accept edge.
- Back-to-back requests: the requester samples ACK and may present the next request on the following cycle. MREQ still high in IDLE is treated as a new request, giving one idle cycle between transactions.
- Errors (ERR=1, no write, LOADDATA=0) are raised for any of:
  - SIZE=11;
  - half access with ADDRESS[0]=1;
  - word access with ADDRESS[1:0]!=00;
  - ADDRESS[ADDR_W-1:2] >= DEPTH_WORDS.
- Stores:
  - The RAM write commits on the edge that enters RESP.
  - Byte lane k=ADDRESS[1:0] receives WRITEDATA[7:0].
  - A half store writes lanes {2h+1,2h}, where h=ADDRESS[1], from WRITEDATA[15:0].
  - A word store writes all four lanes.
  - LOADDATA=0 on a store ACK.
- Loads:
  - The addressed lanes are shifted down to bit 0 and zero-extended; see the optional feature for signed loads.
  - A load issued in the cycle after a store to the same word returns the new data.
- Reset mid-operation: the transaction is abandoned and no ACK is issued. A store is discarded unless its commit edge has already passed; if reset falls on the commit edge, reset wins and nothing is written.

Optional Feature:
- Macro: DMEM_SIGNED_LOAD_EN.
- When defined:
  - Adds input port DMEM_inUNSIGNED (1 bit, captured with the request).
  - Byte and half loads sign-extend from bit 7 or bit 15 when UNSIGNED=0, and zero-extend when UNSIGNED=1.
- When undefined: no extra port; all loads are zero-extended.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD constants;
  - the state enum (IDLE, WAIT, RESP);
  - the wait-counter width function.
- Sub-module dmem_lane_align: purely combinational.
  - Inputs: size and addr[1:0].
  - Outputs: byte-enable[3:0], misalign flag, store-data replication, load-data extraction and extension.
- The FSM and RAM array stay in dmem_responder.

Test Plan:
- Reset and wait states: reset, then word store 0xDEADBEEF to 0x10 with WAIT_CYCLES=2 -> ACK exactly 3 cycles after accept, ERR=0. Word load of 0x10 -> LOADDATA=0xDEADBEEF.
- Byte and half stores: byte store 0xAA to 0x11, then half store 0x1234 to 0x12 -> word load of 0x10 returns 0x1234AAEF.
- Sub-word loads: byte load of 0x13 -> 0x00000012.
  - With DMEM_SIGNED_LOAD_EN and UNSIGNED=0, byte load of 0x11 -> 0xFFFFFFAA.
- Error cases: word store to 0x12, half load of 0x13, SIZE=11, and address 4*DEPTH_WORDS -> each gives ACK with ERR=1 and LOADDATA=0. A following load of 0x10 is unchanged.
- Back-to-back: MREQ held high across ACK -> second request accepted on the cycle after ACK. BUSY is high throughout except that one IDLE cycle.
- Reset mid-transaction: RESETN low during WAIT of a store to 0x20 -> no ACK, outputs 0. A subsequent load of 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Optional build macro used by this slice: DMEM_SIGNED_LOAD_EN.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The wait counter holds at most wait_cycles-1; keep at least one bit.
  function automatic int wait_cnt_w(input int wait_cycles);
    return (wait_cycles <= 2) ? 1 : $clog2(wait_cycles);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: byte enables, store replication, load extraction.
// Sign extension is requested by the parent (DMEM_SIGNED_LOAD_EN builds only).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic        i_sign_ext,
  output logic [3:0]  o_be,
  output logic        o_misalign,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_be        = 4'b0000;
    o_misalign  = 1'b0;
    o_wdata_rep = i_wdata;
    o_rdata     = '0;
    case (i_size)
      SIZE_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata     = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_misalign  = i_addr_lo[0];
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata     = {{16{i_sign_ext & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_be        = 4'b1111;
        o_misalign  = |i_addr_lo;
        o_rdata     = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, WAIT_CYCLES wait states, one-cycle ACK.
// Optional build macro: DMEM_SIGNED_LOAD_EN adds DMEM_inUNSIGNED and sign-extending sub-word loads.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              DMEM_inMREQ,
  input  logic              DMEM_inWRITE,
  input  logic [1:0]        DMEM_inSIZE,
  input  logic [ADDR_W-1:0] DMEM_inADDRESS,
  input  logic [31:0]       DMEM_inWRITEDATA,
`ifdef DMEM_SIGNED_LOAD_EN
  input  logic              DMEM_inUNSIGNED,
`endif
  output logic [31:0]       DMEM_outLOADDATA,
  output logic              DMEM_outACK,
  output logic              DMEM_outBUSY,
  output logic              DMEM_outERR
);

  localparam int               CNT_W     = wait_cnt_w(WAIT_CYCLES);
  localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rword;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_idle;
  logic              w_write;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_unsigned;
  logic              w_enter_resp;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_be;
  logic              w_misalign;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_rdata;

  // In IDLE the live request is used so a zero-wait store can commit on its accept edge;
  // otherwise the captured copy drives everything, including the RESP-cycle outputs.
  assign w_idle  = (r_state == S_IDLE);
  assign w_write = w_idle ? DMEM_inWRITE     : r_write;
  assign w_size  = w_idle ? DMEM_inSIZE      : r_size;
  assign w_addr  = w_idle ? DMEM_inADDRESS   : r_addr;
  assign w_wdata = w_idle ? DMEM_inWRITEDATA : r_wdata;

`ifdef DMEM_SIGNED_LOAD_EN
  logic r_unsigned;
  assign w_unsigned = w_idle ? DMEM_inUNSIGNED : r_unsigned;
  always_ff @(posedge CLK) begin
    if (!RESETN)                    r_unsigned <= 1'b0;
    else if (w_idle && DMEM_inMREQ) r_unsigned <= DMEM_inUNSIGNED;
  end
`else
  assign w_unsigned = 1'b1;
`endif

  assign w_enter_resp = (w_idle && DMEM_inMREQ && (WAIT_CYCLES == 0))
                      || ((r_state == S_WAIT) && (r_cnt == '0));
  assign w_err = (w_size == SIZE_RSVD) || w_misalign || (w_addr[ADDR_W-1:2] >= DEPTH_LIM);
  assign w_idx = w_addr[IDX_W+1:2];

  dmem_lane_align u_align (
    .i_size      (w_size),
    .i_addr_lo   (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .i_rword     (r_rword),
    .i_sign_ext  (~w_unsigned),
    .o_be        (w_be),
    .o_misalign  (w_misalign),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata     (w_rdata)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (DMEM_inMREQ) begin
          r_write <= DMEM_inWRITE;
          r_size  <= DMEM_inSIZE;
          r_addr  <= DMEM_inADDRESS;
          r_wdata <= DMEM_inWRITEDATA;
          r_cnt   <= CNT_INIT;
          r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive RESETN, only the commit is gated by it.
  always_ff @(posedge CLK) begin
    if (RESETN && w_enter_resp) begin
      if (w_write && !w_err) begin
        for (int l = 0; l < 4; l++) begin
          if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata_rep[8*l +: 8];
        end
      end
      if (!w_write) r_rword <= r_mem[w_idx];
    end
  end

  assign DMEM_outACK      = (r_state == S_RESP);
  assign DMEM_outBUSY     = (r_state != S_IDLE);
  assign DMEM_outERR      = DMEM_outACK && w_err;
  assign DMEM_outLOADDATA = (DMEM_outACK && !w_write && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2, DEPTH_WORDS=1024).
// Builds with or without DMEM_SIGNED_LOAD_EN; sub-word load expectations follow the build.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_SIGNED_LOAD_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rstn  = 1'b0;
  logic        mreq  = 1'b0;
  logic        wr    = 1'b0;
  logic [1:0]  sz    = SIZE_WORD;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        uns   = 1'b1;
  logic [31:0] ldata;
  logic        ack, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .CLK              (clk),
    .RESETN           (rstn),
    .DMEM_inMREQ      (mreq),
    .DMEM_inWRITE     (wr),
    .DMEM_inSIZE      (sz),
    .DMEM_inADDRESS   (addr),
    .DMEM_inWRITEDATA (wdata),
`ifdef DMEM_SIGNED_LOAD_EN
    .DMEM_inUNSIGNED  (uns),
`endif
    .DMEM_outLOADDATA (ldata),
    .DMEM_outACK      (ack),
    .DMEM_outBUSY     (busy),
    .DMEM_outERR      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Presents one request, waits for ACK (20-cycle bound), returns latency in cycles after accept.
  task automatic xact(input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [31:0] rd,
                      output logic er);
    @(negedge clk);
    mreq = 1'b1; wr = w; sz = s; addr = a; wdata = d;
    @(posedge clk);
    lat = -1; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack) begin
        lat = c; rd = ldata; er = err;
        break;
      end
    end
    mreq = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mreq = 1'b1; wr = 1'b1; sz = SIZE_WORD; addr = 32'h10; wdata = 32'h5A5A5A5A;
    repeat (3) @(negedge clk);
    n_tests++; if (ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (ldata !== '0)   begin n_fail++; $display("FAIL reset_ldata got %h want 0", ldata); end
    mreq = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_word_store();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF, lat, rd, er);
    n_tests++; if (lat !== 3)      begin n_fail++; $display("FAIL st_latency got %0d want 3", lat); end
    n_tests++; if (er !== 1'b0)    begin n_fail++; $display("FAIL st_err got %b want 0", er); end
    n_tests++; if (rd !== '0)      begin n_fail++; $display("FAIL st_ldata got %h want 0", rd); end
    xact(1'b0, SIZE_WORD, 32'h10, 32'h0, lat, rd, er);
    n_tests++; if (lat !== 3)      begin n_fail++; $display("FAIL ld_latency got %0d want 3", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word got %h want deadbeef", rd); end
    xact(1'b1, SIZE_WORD, 32'h0, 32'h0, lat, rd, er);
    n_tests++; if (er !== 1'b0)    begin n_fail++; $display("FAIL st_zero_err got %b want 0", er); end
  endtask

  typedef struct {
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] zx;
    logic [31:0] sx;
  } ld_vec_t;

  task automatic test_subword();
    int lat; logic [31:0] rd; logic er; logic [31:0] exp;
    ld_vec_t v[6];
    v[0] = '{SIZE_WORD, 32'h10, 32'h1234AAEF, 32'h1234AAEF};
    v[1] = '{SIZE_BYTE, 32'h13, 32'h00000012, 32'h00000012};
    v[2] = '{SIZE_BYTE, 32'h11, 32'h000000AA, 32'hFFFFFFAA};
    v[3] = '{SIZE_BYTE, 32'h10, 32'h000000EF, 32'hFFFFFFEF};
    v[4] = '{SIZE_HALF, 32'h10, 32'h0000AAEF, 32'hFFFFAAEF};
    v[5] = '{SIZE_HALF, 32'h12, 32'h00001234, 32'h00001234};
    xact(1'b1, SIZE_BYTE, 32'h11, 32'hFFFFFFAA, lat, rd, er);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_byte_err got %b want 0", er); end
    xact(1'b1, SIZE_HALF, 32'h12, 32'hFFFF1234, lat, rd, er);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_half_err got %b want 0", er); end
    uns = 1'b0;
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, v[i].s, v[i].a, 32'h0, lat, rd, er);
      exp = SIGNED_BUILD ? v[i].sx : v[i].zx;
      n_tests++;
      if (rd !== exp || lat !== 3) begin
        n_fail++; $display("FAIL subword_ld[%0d] got %h lat %0d want %h lat 3", i, rd, lat, exp);
      end
    end
    uns = 1'b1;
    xact(1'b0, SIZE_BYTE, 32'h11, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'h000000AA) begin n_fail++; $display("FAIL ld_byte_uns got %h want 000000aa", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    logic        ew[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  es[4] = '{SIZE_WORD, SIZE_HALF, SIZE_RSVD, SIZE_WORD};
    logic [31:0] ea[4] = '{32'h12, 32'h13, 32'h10, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      xact(ew[i], es[i], ea[i], 32'hFFFFFFFF, lat, rd, er);
      n_tests++;
      if (lat !== 3 || er !== 1'b1 || rd !== '0) begin
        n_fail++; $display("FAIL err_case[%0d] got lat %0d err %b data %h want lat 3 err 1 data 0",
                           i, lat, er, rd);
      end
    end
    xact(1'b0, SIZE_WORD, 32'h10, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'h1234AAEF) begin n_fail++; $display("FAIL err_no_write got %h want 1234aaef", rd); end
    xact(1'b0, SIZE_WORD, 32'h0, 32'h0, lat, rd, er);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_no_alias got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_busy[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_ack[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    mreq = 1'b1; wr = 1'b0; sz = SIZE_WORD; addr = 32'h10;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== exp_busy[c-1] || ack !== exp_ack[c-1]) begin
        n_fail++; $display("FAIL b2b_cycle%0d got busy %b ack %b want busy %b ack %b",
                           c, busy, ack, exp_busy[c-1], exp_ack[c-1]);
      end
      if (c == 3) begin
        n_tests++; if (ldata !== 32'h1234AAEF) begin n_fail++; $display("FAIL b2b_first got %h want 1234aaef", ldata); end
        addr = 32'h0;
      end
      if (c == 7) begin
        n_tests++; if (ldata !== 32'h0) begin n_fail++; $display("FAIL b2b_second got %h want 0", ldata); end
      end
    end
    mreq = 1'b0;
  endtask

  // Reset lands in the first WAIT cycle (k=1) and then exactly on the commit edge (k=2).
  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int acks;
    xact(1'b1, SIZE_WORD, 32'h20, 32'h11111111, lat, rd, er);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      mreq = 1'b1; wr = 1'b1; sz = SIZE_WORD; addr = 32'h20; wdata = 32'hCAFEF00D;
      @(posedge clk);
      repeat (k) @(negedge clk);
      rstn = 1'b0; mreq = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || ldata !== '0) begin
        n_fail++; $display("FAIL rst_mid%0d_outputs got ack %b busy %b err %b data %h want all 0",
                           k, ack, busy, err, ldata);
      end
      rstn = 1'b1;
      acks = 0;
      repeat (6) begin @(negedge clk); if (ack) acks++; end
      n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid%0d_noack got %0d acks want 0", k, acks); end
      xact(1'b0, SIZE_WORD, 32'h20, 32'h0, lat, rd, er);
      n_tests++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL rst_mid%0d_data got %h want 11111111", k, rd); end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
